serial_add_ctrl: RTL and testbench
==================================

// Module: serial_add_ctrl
// PURPOSE
//   Bit-serial N-bit adder controller. It time-shares one full_adder cell
//   across all WIDTH bit positions, LSB first, and keeps a registered carry.
//   Operands enter through a valid/ready input handshake. The result leaves
//   through a valid/ready output handshake.
//   Used where area matters more than latency. It is the sequencing wrapper
//   around the existing 1-bit full_adder datapath.
// PARAMETERS
//   WIDTH   8   operand/result width in bits; legal range 2..64
// PORTS
//   clk        in   1      single clock; all state updates on rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   in_valid   in   1      operands a/b/cin valid this cycle
//   in_ready   out  1      controller can accept operands (state==S_IDLE)
//   a          in   WIDTH  addend A, sampled on accept
//   b          in   WIDTH  addend B, sampled on accept
//   cin        in   1      carry-in, sampled on accept
//   out_valid  out  1      sum/cout hold a completed result (state==S_DONE)
//   out_ready  in   1      consumer takes the result
//   sum        out  WIDTH  registered result, a+b+cin mod 2^WIDTH
//   cout       out  1      registered carry-out of bit WIDTH-1
//   busy       out  1      state==S_RUN
// BEHAVIOUR
//   Reset (rst_n=0, async)
//     state=S_IDLE, shift regs=0, carry=0, bit counter=0, sum=0, cout=0.
//     Outputs during and after reset: in_ready=1, out_valid=0, busy=0.
//   S_IDLE
//     in_ready=1.
//     Accept edge = in_valid & in_ready: load a_sh<=a, b_sh<=b, carry<=cin,
//     sum<=0, cnt<=0, go to S_RUN.
//   S_RUN
//     Each edge: full_adder inputs are A=a_sh[0], B=b_sh[0], Cin=carry.
//     - sum <= {fa_Sum, sum[WIDTH-1:1]} (shift right, new bit in at MSB)
//     - carry <= fa_Cout
//     - a_sh, b_sh shift right by 1
//     - cnt++
//     On the edge where cnt==WIDTH-1: cout<=fa_Cout, go to S_DONE.
//   Latency: out_valid rises exactly WIDTH edges after the accept edge.
//     Throughput is one result per WIDTH+2 cycles with out_ready held high.
//   S_DONE
//     out_valid=1. sum and cout stay stable until out_valid & out_ready,
//     then go to S_IDLE. in_ready returns 1 the cycle after the handshake.
//   Boundary conditions
//     - in_valid outside S_IDLE is ignored; a/b/cin changes never disturb
//       an operation in flight.
//     - out_ready outside S_DONE is ignored.
//     - No same-cycle accept while in S_DONE: there is no bypass from
//       S_DONE to S_RUN.
//     - Carry wrap: overflow is reported only via cout; sum is mod 2^WIDTH.
//     - rst_n low mid-S_RUN or mid-S_DONE aborts immediately; the partial
//       result is discarded and outputs take their reset values.
//     - cnt width is $clog2(WIDTH). Illegal state encodings recover to
//       S_IDLE.
// STRUCTURE
//   Package serial_add_pkg holds:
//     - state encoding S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2 (2-bit state
//       type)
//     - WIDTH_MIN=2, WIDTH_MAX=64 constants
//   Sub-module: one instance of the existing full_adder (ports A, B, Cin,
//     Sum, Cout). It is the only arithmetic in the block.
//   Everything else is local: FSM, counter, shift registers.
// TESTING (WIDTH=8)
//   1. Reset: hold rst_n=0 over 3 edges -> in_ready=1, out_valid=0, busy=0,
//      sum=8'h00, cout=0.
//   2. a=8'h5A, b=8'h33, cin=0 -> sum=8'h8D, cout=0. out_valid rises
//      exactly 8 edges after accept; busy=1 for those 8 cycles.
//   3. Carry chain: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1.
//      Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
//   4. Backpressure: out_ready=0 for 5 cycles in S_DONE while pulsing
//      in_valid with new operands -> sum/cout unchanged, in_ready=0,
//      nothing accepted.
//   5. Abort: assert rst_n=0 after 3 RUN edges of a=8'hAA, b=8'h55 ->
//      outputs at reset values at once. After release, a=8'h01, b=8'h01
//      gives sum=8'h02, cout=0.
//   6. Back-to-back: in_valid and out_ready held high, 4 random vectors ->
//      each result matches a+b+cin; accept edges spaced exactly 10 cycles.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

    // Controller states; any other encoding recovers to S_IDLE.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Legal range for the operand width.
    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 64;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder: the only arithmetic cell in the serial adder.
module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sum,
    output logic Cout
);

    assign Sum  = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one full_adder reused LSB first, with a
// registered carry, a valid/ready operand input and a valid/ready result.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    // Reject out-of-range widths at elaboration time.
    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("serial_add_ctrl: WIDTH out of range");
    end

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_q;
    logic             carry;
    logic             cout_q;
    logic [CNT_W-1:0] cnt;
    logic             fa_sum;
    logic             fa_cout;
    logic             last_bit;

    assign last_bit = (cnt == CNT_LAST);

    full_adder u_fa (
        .A    (a_sh[0]),
        .B    (b_sh[0]),
        .Cin  (carry),
        .Sum  (fa_sum),
        .Cout (fa_cout)
    );

    // State register.
    // NOTE: sequential state always uses non-blocking (<=) so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and handshake outputs, all derived from the state.
    // NOTE: every output gets a default before the case so no path leaves a
    // value unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: load operands on accept, then shift one bit per RUN edge.
    // NOTE: the shift registers are plain flops, not a memory, so they are
    // reset along with the rest of the state for a clean abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_q  <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            cnt    <= '0;
        end else if (state == S_IDLE && in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            sum_q <= '0;
            cnt   <= '0;
        end else if (state == S_RUN) begin
            sum_q <= {fa_sum, sum_q[WIDTH-1:1]};
            carry <= fa_cout;
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            cnt   <= cnt + CNT_W'(1);
            if (last_bit) begin
                cout_q <= fa_cout;
            end
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phases of an operation: waiting, computing for WIDTH edges, holding.
    typedef enum {M_IDLE, M_CALC, M_HOLD} mphase_t;

    mphase_t          m_phase = M_IDLE;
    int               m_left  = 0;
    logic [WIDTH:0]   m_pend  = '0;
    logic [WIDTH-1:0] m_sum   = '0;
    logic             m_cout  = 1'b0;
    int               cyc     = 0;
    int               n_acc   = 0;
    int               acc_cyc [64];
    int               n_done  = 0;

    always @(posedge clk) cyc++;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = M_IDLE;
            m_left  = 0;
            m_sum   = '0;
            m_cout  = 1'b0;
        end else begin
            case (m_phase)
                M_IDLE: if (in_valid) begin
                    m_pend = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
                    m_left = WIDTH;
                    m_phase = M_CALC;
                    if (n_acc < 64) acc_cyc[n_acc] = cyc;
                    n_acc++;
                end
                M_CALC: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = M_HOLD;
                        m_sum   = m_pend[WIDTH-1:0];
                        m_cout  = m_pend[WIDTH];
                    end
                end
                default: if (out_ready) begin
                    m_phase = M_IDLE;
                    n_done++;
                end
            endcase
        end
    end

    // Compare DUT against the model every cycle, away from the clock edge.
    always @(negedge clk) begin
        check("in_ready", in_ready, m_phase == M_IDLE);
        check("busy", busy, m_phase == M_CALC);
        check("out_valid", out_valid, m_phase == M_HOLD);
        if (m_phase != M_CALC) begin
            check("sum", sum, m_sum);
            check("cout", cout, m_cout);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input logic vc);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        a = va;
        b = vb;
        cin = vc;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        cin = 1'($urandom);
        check("accept_timeout", ok, 1'b1);
    endtask

    task automatic wait_done(output logic [WIDTH-1:0] s, output logic c, output int nbusy);
        bit ok;
        ok = 1'b0;
        nbusy = 0;
        s = 'x;
        c = 1'bx;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (out_valid) begin
                s = sum;
                c = cout;
                ok = 1'b1;
                break;
            end
        end
        check("done_timeout", ok, 1'b1);
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    logic [WIDTH-1:0] rs;
    logic             rc;
    int               nb;
    logic [WIDTH-1:0] va [4];
    logic [WIDTH-1:0] vb [4];
    logic             vc [4];
    int               n0;
    int               d0;
    bit               got;

    initial begin
        in_valid = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        out_ready = 1'b0;

        // 1. Reset held over 3 edges.
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_sum", sum, 8'h00);
        check("rst_cout", cout, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 2. Basic add with latency.
        send(8'h5A, 8'h33, 1'b0);
        wait_done(rs, rc, nb);
        check("t2_sum", rs, 8'h8D);
        check("t2_cout", rc, 1'b0);
        check("t2_busy_cycles", nb, 8);
        take();

        // 3. Carry chain.
        send(8'hFF, 8'h01, 1'b0);
        wait_done(rs, rc, nb);
        check("t3a_sum", rs, 8'h00);
        check("t3a_cout", rc, 1'b1);
        take();
        send(8'hFF, 8'hFF, 1'b1);
        wait_done(rs, rc, nb);
        check("t3b_sum", rs, 8'hFF);
        check("t3b_cout", rc, 1'b1);

        // 4. Backpressure while new operands are offered.
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            cin = 1'($urandom);
            @(negedge clk);
            check("t4_hold_sum", sum, 8'hFF);
            check("t4_hold_cout", cout, 1'b1);
            check("t4_in_ready", in_ready, 1'b0);
            check("t4_out_valid", out_valid, 1'b1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        take();
        @(negedge clk);
        check("t4_idle_ready", in_ready, 1'b1);
        check("t4_not_busy", busy, 1'b0);
        @(posedge clk);
        #1;

        // 5. Abort mid-run.
        send(8'hAA, 8'h55, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("t5_busy_mid", busy, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_in_ready", in_ready, 1'b1);
        check("t5_out_valid", out_valid, 1'b0);
        check("t5_busy", busy, 1'b0);
        check("t5_sum", sum, 8'h00);
        check("t5_cout", cout, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(8'h01, 8'h01, 1'b0);
        wait_done(rs, rc, nb);
        check("t5_sum_after", rs, 8'h02);
        check("t5_cout_after", rc, 1'b0);
        take();

        // 6. Back-to-back with in_valid and out_ready held high.
        for (int k = 0; k < 4; k++) begin
            va[k] = WIDTH'($urandom);
            vb[k] = WIDTH'($urandom);
            vc[k] = 1'($urandom);
        end
        n0 = n_acc;
        d0 = n_done;
        out_ready = 1'b1;
        a = va[0];
        b = vb[0];
        cin = vc[0];
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            got = 1'b0;
            for (int t = 0; t < 40; t++) begin
                @(posedge clk);
                #1;
                if (n_acc == n0 + k + 1) begin
                    got = 1'b1;
                    break;
                end
            end
            check("t6_accept_timeout", got, 1'b1);
            check("t6_model_result", m_pend, {1'b0, va[k]} + {1'b0, vb[k]} + {{WIDTH{1'b0}}, vc[k]});
            if (k < 3) begin
                a = va[k+1];
                b = vb[k+1];
                cin = vc[k+1];
            end else begin
                in_valid = 1'b0;
            end
        end
        repeat (12) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check("t6_spacing", acc_cyc[n0+k+1] - acc_cyc[n0+k], 10);
        end
        check("t6_results", n_done - d0, 4);
        out_ready = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
